inst_fetch_responder: RTL

- Responder side of the instruction-fetch request/response interface.
- Accepts one fetch request at a time from the pre-IF request stage. Returns exactly one data_ok plus instruction word per accepted request to the IF stage.
- Holds a single-line fetch buffer, refilled by an AXI4 INCR burst read on a miss.
- Sits between the fetch pipeline and the AXI read channel. Exposes inst_req_busy, which IF uses to arm its discard-on-flush logic.

---
 rtl/inst_fetch_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: one-line fetch buffer refilled by AXI4 INCR burst.
// Ports: clk/reset, inst_* fetch handshake, invalidate, AXI AR/R read channels.
module inst_fetch_responder #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AR_ID      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_bus_err,
  output logic        inst_req_busy,
  input  logic        invalidate,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam int IW   = $clog2(LINE_WORDS);
  localparam int OFFS = IW + 2;
  localparam int TW   = 32 - OFFS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_RSP,
    S_AR,
    S_R,
    S_RSP
  } state_t;

  state_t          r_state;
  logic            r_line_valid;
  logic [TW-1:0]   r_tag;
  logic [31:0]     r_words [LINE_WORDS];
  logic [TW-1:0]   r_req_tag;
  logic [IW-1:0]   r_req_idx;
  logic [IW-1:0]   r_cnt;
  logic            r_err;
  logic            r_kill;
  logic            r_data_ok;
  logic            r_bus_err;
  logic [31:0]     r_rdata;
  logic            r_arvalid;
  logic [31:0]     r_araddr;
  logic            r_rready;

  logic            w_accept;
  logic            w_hit;
  logic            w_beat_err;
  logic            w_err_n;
  logic            w_kill_n;
  logic            w_full;
  logic [TW-1:0]   w_in_tag;
  logic [IW-1:0]   w_in_idx;
  logic            w_unused;

  assign w_in_tag   = inst_addr[31:OFFS];
  assign w_in_idx   = inst_addr[OFFS-1:2];
  assign w_accept   = inst_req & (r_state == S_IDLE);
  assign w_hit      = r_line_valid & (r_tag == w_in_tag) & ~invalidate;
  assign w_beat_err = (rresp != 2'b00);
  assign w_err_n    = r_err | w_beat_err;
  assign w_kill_n   = r_kill | invalidate;
  assign w_full     = (r_cnt == IW'(LINE_WORDS - 1));
  assign w_unused   = ^inst_addr[1:0];

  assign inst_addr_ok  = w_accept;
  assign inst_req_busy = (r_state != S_IDLE);
  assign inst_data_ok  = r_data_ok;
  assign inst_rdata    = r_rdata;
  assign inst_bus_err  = r_bus_err;

  assign arvalid = r_arvalid;
  assign araddr  = r_araddr;
  assign arid    = AR_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign rready  = r_rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_line_valid <= 1'b0;
      r_tag        <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_words[i] <= '0;
      end
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_kill       <= 1'b0;
      r_data_ok    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_rdata      <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (invalidate) begin
            r_line_valid <= 1'b0;
          end
          if (w_accept) begin
            r_req_tag <= w_in_tag;
            r_req_idx <= w_in_idx;
            if (w_hit) begin
              r_state   <= S_HIT_RSP;
              r_data_ok <= 1'b1;
              r_bus_err <= 1'b0;
              r_rdata   <= r_words[w_in_idx];
            end else begin
              r_state      <= S_AR;
              r_line_valid <= 1'b0;
              r_arvalid    <= 1'b1;
              r_araddr     <= {w_in_tag, {OFFS{1'b0}}};
            end
          end
        end
        S_HIT_RSP: begin
          r_data_ok <= 1'b0;
          if (invalidate) begin
            r_line_valid <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        S_AR: begin
          // A flush of the line while the refill is in flight must not
          // abandon the burst; it only blocks validation at the end.
          if (invalidate) begin
            r_kill <= 1'b1;
          end
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (invalidate) begin
            r_kill <= 1'b1;
          end
          if (rvalid) begin
            r_words[r_cnt] <= rdata;
            r_cnt          <= r_cnt + IW'(1);
            if (r_cnt == r_req_idx) begin
              r_rdata <= rdata;
            end
            if (w_beat_err) begin
              r_err <= 1'b1;
            end
            if (rlast) begin
              r_state      <= S_RSP;
              r_rready     <= 1'b0;
              r_cnt        <= '0;
              r_tag        <= r_req_tag;
              // Only a clean, complete, unkilled burst may fill the line.
              r_line_valid <= ~w_err_n & ~w_kill_n & w_full;
              r_data_ok    <= 1'b1;
              r_bus_err    <= w_err_n;
              if (w_err_n) begin
                r_rdata <= '0;
              end
            end
          end
        end
        S_RSP: begin
          r_data_ok <= 1'b0;
          r_bus_err <= 1'b0;
          r_err     <= 1'b0;
          r_kill    <= 1'b0;
          if (invalidate) begin
            r_line_valid <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
